// File: rtl/gpi_poll_ctrl_if.sv
// APB bus between the GPI poll controller (master) and the GPI slave.
interface gpi_poll_ctrl_if;
    logic [2:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/gpi_poll_ctrl.sv
// Autonomous APB master for the GPI peripheral: writes CR once, then polls IDR
// at a programmable interval, keeping the last masked sample, sticky per-bit
// change flags and a level interrupt.
module gpi_poll_ctrl #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned TO_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                start,
    input  logic                stop,
    input  logic [7:0]          cfg_cr,
    input  logic [DIV_W-1:0]    poll_div,
    input  logic [7:0]          chg_clr,
    gpi_poll_ctrl_if.master     apb,
    output logic [7:0]          gpi_val,
    output logic [7:0]          gpi_chg,
    output logic                irq,
    output logic                err,
    output logic                busy
);

    localparam int unsigned ToW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCfgSetup,
        StCfgAccess,
        StRdSetup,
        StRdAccess,
        StWait
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cr_q, cr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [ToW-1:0]   to_q, to_d;
    logic             first_q, first_d;
    logic             pend_q, pend_d;
    logic [7:0]       val_q, val_d;
    logic [7:0]       chg_q, chg_d;
    logic             irq_q, irq_d;
    logic             err_q, err_d;

    logic [2:0]       paddr;
    logic             psel, penable, pwrite;
    logic [31:0]      pwdata;
    logic [7:0]       sample;
    logic [7:0]       set_vec;
    logic             to_hit;

    // Next-state, APB outputs and sample/flag update.
    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        first_d = first_q;
        pend_d  = pend_q;
        val_d   = val_q;
        err_d   = err_q;
        set_vec = 8'h00;
        paddr   = 3'd0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        // Disabled pins may float on the bus; the CR mask forces them to 0.
        sample  = apb.PRDATA[7:0] & cr_q;
        to_hit  = (to_q == ToW'(TO_CYC - 1));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCfgSetup;
                    cr_d    = cfg_cr;
                    div_d   = poll_div;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            StCfgSetup: begin
                psel    = 1'b1;
                pwrite  = 1'b1;
                pwdata  = {24'h0, cr_q};
                pend_d  = pend_q | stop;
                to_d    = '0;
                state_d = StCfgAccess;
            end
            StCfgAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = 1'b1;
                pwdata  = {24'h0, cr_q};
                pend_d  = pend_q | stop;
                if (apb.PREADY) begin
                    state_d = (pend_q | stop) ? StIdle : StRdSetup;
                    pend_d  = 1'b0;
                end else if (to_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StRdSetup: begin
                psel    = 1'b1;
                paddr   = 3'd4;
                pend_d  = pend_q | stop;
                to_d    = '0;
                state_d = StRdAccess;
            end
            StRdAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                paddr   = 3'd4;
                pend_d  = pend_q | stop;
                if (apb.PREADY) begin
                    // The very first sample after start only seeds gpi_val.
                    if (!first_q) begin
                        set_vec = sample ^ val_q;
                    end
                    first_d = 1'b0;
                    val_d   = sample;
                    cnt_d   = div_q;
                    state_d = (pend_q | stop) ? StIdle : StWait;
                    pend_d  = 1'b0;
                end else if (to_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StRdSetup;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A bit set and cleared in the same cycle stays set.
        chg_d = (chg_q & ~chg_clr) | set_vec;
        irq_d = |chg_q;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q <= StIdle;
            cr_q    <= 8'h00;
            div_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            first_q <= 1'b1;
            pend_q  <= 1'b0;
            val_q   <= 8'h00;
            chg_q   <= 8'h00;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            val_q   <= val_d;
            chg_q   <= chg_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign apb.PADDR   = paddr;
    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PWRITE  = pwrite;
    assign apb.PWDATA  = pwdata;

    assign gpi_val = val_q;
    assign gpi_chg = chg_q;
    assign irq     = irq_q;
    assign err     = err_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_gpi_poll_ctrl.sv
// Directed bench for gpi_poll_ctrl with a registered-PREADY GPI slave model.
module tb_gpi_poll_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        start, stop;
    logic [7:0]  cfg_cr;
    logic [15:0] poll_div;
    logic [7:0]  chg_clr;
    logic [7:0]  gpi_val, gpi_chg;
    logic        irq, err, busy;

    logic [7:0]  gpi_drv;
    logic        slave_en;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [2:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [2:0]  last_rd_addr;
    int gap_run  = 0;
    int last_gap = 0;
    int base, wbase, n_acc;

    gpi_poll_ctrl_if bus ();

    gpi_poll_ctrl #(.DIV_W(16), .TO_CYC(16)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .start    (start),
        .stop     (stop),
        .cfg_cr   (cfg_cr),
        .poll_div (poll_div),
        .chg_clr  (chg_clr),
        .apb      (bus.master),
        .gpi_val  (gpi_val),
        .gpi_chg  (gpi_chg),
        .irq      (irq),
        .err      (err),
        .busy     (busy)
    );

    always #5 PCLK = ~PCLK;

    assign bus.PRDATA = {24'h0, gpi_drv};

    // Slave: raise PREADY one cycle into ACCESS, drop it after completion.
    initial bus.PREADY = 1'b0;
    always @(negedge PCLK) begin
        if (!PRESET || !slave_en) bus.PREADY = 1'b0;
        else bus.PREADY = bus.PSEL && bus.PENABLE && !bus.PREADY;
    end

    // Log completed transfers as seen at the completing edge.
    always @(posedge PCLK) begin
        if (PRESET && bus.PSEL && bus.PENABLE && bus.PREADY) begin
            if (bus.PWRITE) begin
                wr_cnt++;
                last_wr_addr = bus.PADDR;
                last_wr_data = bus.PWDATA;
            end else begin
                rd_cnt++;
                last_rd_addr = bus.PADDR;
            end
        end
    end

    // Length of the bus-idle run between two polls.
    always @(negedge PCLK) begin
        if (!busy) gap_run = 0;
        else if (bus.PSEL) begin
            if (gap_run > 0) last_gap = gap_run;
            gap_run = 0;
        end else gap_run++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_rd(input int n, input string tag);
        for (int i = 0; i < 200 && rd_cnt < n; i++) @(negedge PCLK);
        chk(tag, 32'(rd_cnt), 32'(n));
    endtask

    task automatic wait_en(input string tag);
        for (int i = 0; i < 50 && bus.PENABLE !== 1'b1; i++) @(negedge PCLK);
        chk(tag, {31'h0, bus.PENABLE}, 32'h1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
    endtask

    initial begin
        PRESET = 1'b0; start = 1'b0; stop = 1'b0; cfg_cr = 8'h00; poll_div = 16'h0;
        chg_clr = 8'h00; gpi_drv = 8'h00; slave_en = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", {31'h0, bus.PSEL}, 32'h0);
        chk("rst_outs", {19'h0, gpi_val, gpi_chg, irq, err, busy}, 32'h0);
        PRESET = 1'b1;

        // Configure and first sample.
        cfg_cr = 8'hFF; poll_div = 16'd3; gpi_drv = 8'hA5;
        @(negedge PCLK);
        pulse_start();
        wait_rd(1, "t1_rd");
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("t1_wr_addr", {29'h0, last_wr_addr}, 32'h0);
        chk("t1_wr_data", last_wr_data, 32'h0000_00FF);
        chk("t1_rd_addr", {29'h0, last_rd_addr}, 32'h4);
        chk("t1_val", {24'h0, gpi_val}, 32'hA5);
        chk("t1_chg", {24'h0, gpi_chg}, 32'h0);
        chk("t1_irq", {31'h0, irq}, 32'h0);

        // Bit 0 changes; irq follows one cycle later; 4 idle cycles between polls.
        gpi_drv = 8'hA4;
        wait_rd(2, "t2_rd");
        chk("t2_chg", {24'h0, gpi_chg}, 32'h01);
        chk("t2_irq_lag", {31'h0, irq}, 32'h0);
        @(negedge PCLK);
        chk("t2_irq", {31'h0, irq}, 32'h1);
        wait_rd(3, "t2_rd3");
        chk("t2_gap", 32'(last_gap), 32'd4);

        // Set and clear of bit 0 in the same cycle: set wins.
        gpi_drv = 8'hA5;
        wait_en("t4_en");
        chg_clr = 8'h01;
        @(negedge PCLK);
        chg_clr = 8'h00;
        chk("t4_rd", 32'(rd_cnt), 32'd4);
        chk("t4_val", {24'h0, gpi_val}, 32'hA5);
        chk("t4_setwins", {24'h0, gpi_chg}, 32'h01);
        chg_clr = 8'h01;
        @(negedge PCLK);
        chg_clr = 8'h00;
        chk("t4_clr", {24'h0, gpi_chg}, 32'h00);
        @(negedge PCLK);
        chk("t4_irq_clr", {31'h0, irq}, 32'h0);

        // stop during RD_ACCESS: transfer completes, sample applied, then idle.
        gpi_drv = 8'hA4;
        wait_en("t6_en");
        base = rd_cnt;
        stop = 1'b1;
        @(negedge PCLK);
        stop = 1'b0;
        chk("t6_rd", 32'(rd_cnt), 32'(base + 1));
        chk("t6_val", {24'h0, gpi_val}, 32'hA4);
        chk("t6_chg", {24'h0, gpi_chg}, 32'h01);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        repeat (20) @(negedge PCLK);
        chk("t6_no_more_rd", 32'(rd_cnt), 32'(base + 1));

        // Masked pins: upper nibble undriven, CR enables only the lower nibble.
        chg_clr = 8'hFF;
        @(negedge PCLK);
        chg_clr = 8'h00;
        cfg_cr = 8'h0F; poll_div = 16'd0; gpi_drv = 8'bxxxx_1111;
        base = rd_cnt;
        pulse_start();
        wait_rd(base + 1, "t3_rd");
        chk("t3_val", {24'h0, gpi_val}, 32'h0F);
        chk("t3_chg", {24'h0, gpi_chg}, 32'h00);
        // start and new config while busy are ignored.
        wbase = wr_cnt;
        cfg_cr = 8'hFF; poll_div = 16'd7; gpi_drv = 8'bxxxx_0111;
        pulse_start();
        wait_rd(base + 3, "t3_rd3");
        chk("t3_ign_wr", 32'(wr_cnt), 32'(wbase));
        chk("t3_ign_val", {24'h0, gpi_val}, 32'h07);
        chk("t3_ign_chg", {24'h0, gpi_chg}, 32'h08);
        wait_rd(base + 4, "t3_rd4");
        chk("t3_gap", 32'(last_gap), 32'd1);
        // stop in WAIT returns to idle at the next edge.
        stop = 1'b1;
        @(negedge PCLK);
        stop = 1'b0;
        chk("t3_stop_wait", {31'h0, busy}, 32'h0);

        // PREADY never arrives: abort after 16 ACCESS cycles.
        chg_clr = 8'hFF;
        @(negedge PCLK);
        chg_clr = 8'h00;
        slave_en = 1'b0;
        wbase = wr_cnt;
        pulse_start();
        n_acc = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            if (bus.PENABLE) n_acc++;
            @(negedge PCLK);
        end
        chk("t5_acc_cycles", 32'(n_acc), 32'd16);
        chk("t5_err", {31'h0, err}, 32'h1);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_bus", {30'h0, bus.PSEL, bus.PENABLE}, 32'h0);
        chk("t5_val_kept", {24'h0, gpi_val}, 32'h07);
        chk("t5_no_wr", 32'(wr_cnt), 32'(wbase));
        slave_en = 1'b1;
        pulse_start();
        chk("t5_err_clr", {31'h0, err}, 32'h0);

        // Reset in the middle of an ACCESS phase.
        wait_en("t6_rst_en");
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("t6_rst_bus", {30'h0, bus.PSEL, bus.PENABLE}, 32'h0);
        chk("t6_rst_outs", {19'h0, gpi_val, gpi_chg, irq, err, busy}, 32'h0);
        PRESET = 1'b1;
        @(negedge PCLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
